// File: rtl/imem_loadable.sv
// imem_loadable: parametrised, loadable instruction memory.
//
// A sequential bootstrap loader writes words at an auto-incrementing address.
// A registered fetch port returns one result per request, one cycle later.
//
// Optional feature macro: IMEM_PARITY_EN
//   defined   - each stored word carries an even-parity bit, and parity_err
//               flags a mismatch on valid, in-range fetches.
//   undefined - the array is DATA_WIDTH wide and parity_err is tied to 0.
//
// Handshakes:
//   loader - a word transfers on any cycle where load_valid && load_ready.
//            load_ready is high only in LOAD. A load_start in the same cycle
//            wins over load_valid, and that data word is dropped.
//   fetch  - there is no ready signal; every cycle with fetch_req high is
//            accepted. fetch_valid pulses exactly one cycle later for each
//            accepted request.
//
// State encoding on o_dbg_state: 0 = IDLE, 1 = LOAD, 2 = RUN.
module imem_loadable #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // bootstrap loader stream
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   loaded_cnt,
  output logic                  run,
  // fetch port
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_err,
  output logic                  parity_err,
  // debug view of the control FSM
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ADDR_WIDTH-1:0]   r_wptr;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [MEM_W-1:0]        r_mem [DEPTH];

  logic                    r_fetch_valid;
  logic [DATA_WIDTH-1:0]   r_fetch_instr;
  logic                    r_fetch_err;
  logic                    r_parity_err;

  logic                    w_in_load;
  logic                    w_in_run;
  logic                    w_write_en;
  logic                    w_wptr_at_end;
  logic                    w_in_range;
  logic [MEM_W-1:0]        w_wr_word;
  logic [MEM_W-1:0]        w_rd_word;
  logic                    w_rd_perr;

  // The last slot of the array ends the load even without load_last.
  assign w_wptr_at_end = &r_wptr;

  // A word is written only in LOAD, and only when no restart is requested.
  assign w_write_en = w_in_load && load_valid && !load_start;

  // The address is compared against the count, so a partial program
  // never exposes stale words left in the array from an earlier load.
  assign w_in_range = {1'b0, fetch_addr} < r_cnt;

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {^load_data, load_data};
  // Recomputed data parity XOR the stored parity bit is the XOR of all bits.
  assign w_rd_perr = ^w_rd_word;
`else
  assign w_wr_word = load_data;
  assign w_rd_perr = 1'b0;
`endif

  assign w_rd_word = r_mem[fetch_addr];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic. load_start restarts from any state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_start) begin
          w_state_next = ST_LOAD;
        end else if (load_valid && (load_last || w_wptr_at_end)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_in_load = 1'b0;
    w_in_run  = 1'b0;
    case (r_state)
      ST_LOAD: w_in_load = 1'b1;
      ST_RUN:  w_in_run  = 1'b1;
      default: begin
        w_in_load = 1'b0;
        w_in_run  = 1'b0;
      end
    endcase
  end

  // Write pointer and stored-word count. Both are cleared by a restart.
  // After the final slot the pointer wraps to 0, but the FSM is in RUN by
  // then, so no further write can happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (load_start) begin
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (w_write_en) begin
      r_wptr <= r_wptr + 1'b1;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Storage array write port. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_write_en) begin
      r_mem[r_wptr] <= w_wr_word;
    end
  end

  // Registered fetch port: one result per request, one cycle later.
  // Fetches outside RUN or beyond the loaded count return NOP_WORD with an
  // error flag. fetch_instr holds its value between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_instr <= NOP_WORD;
      r_fetch_err   <= 1'b0;
      r_parity_err  <= 1'b0;
    end else if (fetch_req) begin
      r_fetch_valid <= 1'b1;
      if (w_in_run && w_in_range) begin
        r_fetch_instr <= w_rd_word[DATA_WIDTH-1:0];
        r_fetch_err   <= 1'b0;
        r_parity_err  <= w_rd_perr;
      end else begin
        r_fetch_instr <= NOP_WORD;
        r_fetch_err   <= 1'b1;
        r_parity_err  <= 1'b0;
      end
    end else begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_parity_err  <= 1'b0;
    end
  end

  assign load_ready  = w_in_load;
  assign run         = w_in_run;
  assign loaded_cnt  = r_cnt;
  assign fetch_valid = r_fetch_valid;
  assign fetch_instr = r_fetch_instr;
  assign fetch_err   = r_fetch_err;
  assign parity_err  = r_parity_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed bench for imem_loadable.
// Every fetch pushes its expected {instr, err, perr} onto exp_q. A monitor
// pops an entry and compares it each time fetch_valid is seen.
module tb_imem_loadable;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] NOP = 16'h0000;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW:0]   loaded_cnt;
  logic          run;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_instr;
  logic          fetch_err;
  logic          parity_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int consec = 0;
  int max_consec = 0;

  // expected fetch result: {instr[17:2], err[1], perr[0]}
  logic [DW+1:0] exp_q[$];

  // reference model of the memory contents and control state
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_perr [DEPTH];
  int            m_cnt = 0;
  bit            m_load = 0;
  bit            m_run = 0;

  imem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .loaded_cnt(loaded_cnt),
    .run(run), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .parity_err(parity_err), .o_dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      consec++;
      if (consec > max_consec) max_consec = consec;
      if (exp_q.size() == 0) begin
        chk("spurious_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        chk("fetch_instr", {16'b0, fetch_instr}, {16'b0, e[DW+1:2]});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, e[1]});
        chk("parity_err", {31'b0, parity_err}, {31'b0, e[0]});
      end
    end else begin
      consec = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW+1:0] model_fetch(input int addr);
    if (m_run && addr < m_cnt) return {m_mem[addr], 1'b0, m_perr[addr]};
    return {NOP, 1'b1, 1'b0};
  endfunction

  task automatic issue(input int addr);
    fetch_req = 1'b1;
    fetch_addr = AW'(addr);
    exp_q.push_back(model_fetch(addr));
    tick();
  endtask

  task automatic drain();
    fetch_req = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic fetch1(input int addr);
    issue(addr);
    drain();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_load = 1; m_run = 0; m_cnt = 0;
  endtask

  // restart and a data word in the same cycle: the word must be dropped
  task automatic start_collide(input logic [DW-1:0] d);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data = d;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    m_load = 1; m_run = 0; m_cnt = 0;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input bit last);
    chk("load_ready_pre", {31'b0, load_ready}, {31'b0, m_load});
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    if (m_load) begin
      m_mem[m_cnt] = d;
      m_perr[m_cnt] = 1'b0;
      m_cnt++;
      if (last || m_cnt == DEPTH) begin
        m_load = 0;
        m_run = 1;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_load_ready"}, {31'b0, load_ready}, 32'd0);
    chk({ph, "_loaded_cnt"}, {25'b0, loaded_cnt}, 32'd0);
    chk({ph, "_run"}, {31'b0, run}, 32'd0);
    chk({ph, "_fetch_valid"}, {31'b0, fetch_valid}, 32'd0);
    chk({ph, "_fetch_instr"}, {16'b0, fetch_instr}, {16'b0, NOP});
    chk({ph, "_fetch_err"}, {31'b0, fetch_err}, 32'd0);
    chk({ph, "_parity_err"}, {31'b0, parity_err}, 32'd0);
    chk({ph, "_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // fetch with no program loaded
    fetch1(0);

    // three-word program; a fetch during the load must error
    start_load();
    chk("load_ready_in_load", {31'b0, load_ready}, 32'd1);
    chk("state_load", {30'b0, dbg_state}, 32'd1);
    load_word(16'h1111, 0);
    fetch1(0);
    load_word(16'h2222, 0);
    load_word(16'h3333, 1);
    chk("cnt_3", {25'b0, loaded_cnt}, 32'd3);
    chk("run_3", {31'b0, run}, 32'd1);
    chk("ready_after_last", {31'b0, load_ready}, 32'd0);
    chk("state_run", {30'b0, dbg_state}, 32'd2);
    fetch1(1);
    fetch1(3);
    fetch1(2);

    // back-to-back fetches at full throughput
    max_consec = 0;
    issue(0);
    issue(2);
    issue(1);
    drain();
    chk("b2b_consecutive_valids", max_consec, 32'd3);

    // full-depth load without load_last, starting with a restart collision
    start_load();
    load_word(16'hAAAA, 0);
    start_collide(16'hDEAD);
    chk("collide_cnt", {25'b0, loaded_cnt}, 32'd0);
    chk("collide_state", {30'b0, dbg_state}, 32'd1);
    for (int i = 0; i < DEPTH; i++) load_word(16'($urandom_range(0, 16'hFFFF)), 0);
    chk("full_run", {31'b0, run}, 32'd1);
    chk("full_cnt", {25'b0, loaded_cnt}, 32'd64);
    chk("full_ready", {31'b0, load_ready}, 32'd0);
    load_word(16'hBEEF, 0);
    chk("full_no_overwrite_cnt", {25'b0, loaded_cnt}, 32'd64);
    fetch1(63);
    fetch1(0);
    fetch1(62);

`ifdef IMEM_PARITY_EN
    // corrupt one stored bit and expect a parity error on that word only
    start_load();
    load_word(16'h0001, 0);
    load_word(16'h0003, 0);
    load_word(16'h0007, 1);
    dut.r_mem[2][0] = ~dut.r_mem[2][0];
    m_mem[2] = m_mem[2] ^ 16'h0001;
    m_perr[2] = 1'b1;
    fetch1(2);
    fetch1(0);
`endif

    // reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) load_word(16'(16'h0100 + i), 0);
    issue(1);
    fetch_req = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    m_load = 0; m_run = 0; m_cnt = 0;
    #1;
    chk_reset_outputs("midload_reset");
    tick();
    rst_n = 1'b1;
    tick();
    fetch1(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
